// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver, command decoder and pixel-download sequencer.
// Receives 8N1 (optionally with odd/even parity) frames on RX, decodes
// command bytes into video-pipeline selects, and streams downloaded image
// bytes (header: width, height; then width*height pixels) to the frame store.
// Ports:
//   CLK, RST (async, active high), RX (raw serial, idle high)
//   byte_data/byte_valid            last good byte + 1-cycle strobe
//   img_select/res_select/out_select/mon_reset   decoded command selects
//   pix_en/pix_data/pix_valid/pix_done           download stream
//   img_hres/img_vres               downloaded image dimensions
//   frame_err/parity_err/timeout_err             1-cycle error pulses
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [1:0] img_select,
  output logic [1:0] res_select,
  output logic       out_select,
  output logic       mon_reset,
  output logic       pix_en,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  output logic       pix_done,
  output logic [7:0] img_hres,
  output logic [7:0] img_vres,
  output logic       frame_err,
  output logic       parity_err,
  output logic       timeout_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic PAR_ON  = (PARITY != 0);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    D_CMD, D_HDR_H, D_HDR_V, D_PIXEL
  } dec_state_t;

  rx_state_t  rx_state;
  dec_state_t dec_state;

  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bad;
  logic [TW-1:0] idle_cnt;
  logic [15:0]   remaining;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          par_bad <= 1'b0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            // Line back high at the start midpoint is a glitch, not a frame.
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= PAR_ON ? RX_PAR : RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_PAR: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt  <= '0;
            par_bad  <= ((^shift) ^ rx_sync) != PAR_ODD;
            rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              frame_err <= 1'b1;
              rx_state  <= RX_WAIT;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_state   <= D_CMD;
      idle_cnt    <= '0;
      remaining   <= '0;
      img_select  <= '0;
      res_select  <= '0;
      out_select  <= 1'b0;
      mon_reset   <= 1'b0;
      pix_en      <= 1'b0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_done    <= 1'b0;
      img_hres    <= '0;
      img_vres    <= '0;
      timeout_err <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      pix_done    <= 1'b0;
      timeout_err <= 1'b0;
      if (dec_state == D_CMD) begin
        // Holding the timer at zero here makes every download start fresh.
        idle_cnt <= '0;
        if (byte_valid) begin
          if (byte_data[7:6] == 2'b00) begin
            img_select <= byte_data[5:4];
            res_select <= byte_data[3:2];
            out_select <= byte_data[1];
            mon_reset  <= byte_data[0];
          end else if (byte_data[7:6] == 2'b01) begin
            dec_state <= D_HDR_H;
            pix_en    <= 1'b1;
          end
        end
      end else if (byte_valid) begin
        idle_cnt <= '0;
        case (dec_state)
          D_HDR_H: begin
            img_hres  <= byte_data;
            dec_state <= D_HDR_V;
          end
          D_HDR_V: begin
            img_vres  <= byte_data;
            remaining <= {8'd0, img_hres} * {8'd0, byte_data};
            if (img_hres == 8'd0 || byte_data == 8'd0) begin
              pix_done  <= 1'b1;
              pix_en    <= 1'b0;
              dec_state <= D_CMD;
            end else begin
              dec_state <= D_PIXEL;
            end
          end
          D_PIXEL: begin
            pix_data  <= byte_data;
            pix_valid <= 1'b1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              pix_done  <= 1'b1;
              pix_en    <= 1'b0;
              dec_state <= D_CMD;
            end
          end
          default: dec_state <= D_CMD;
        endcase
      end else if (idle_cnt == TO_LAST) begin
        timeout_err <= 1'b1;
        pix_en      <= 1'b0;
        idle_cnt    <= '0;
        dec_state   <= D_CMD;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: randomized self-checking bench for uart_cmd_rx.
// Drives serial frames into a no-parity instance and an even-parity instance
// and compares observed pulses/outputs with a byte-level reference model.
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int TO  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx2 = 1'b1;

  always #5 clk = ~clk;

  logic [7:0] a_byte_data, a_pix_data, a_img_hres, a_img_vres;
  logic [1:0] a_img_select, a_res_select;
  logic a_byte_valid, a_out_select, a_mon_reset, a_pix_en, a_pix_valid, a_pix_done;
  logic a_frame_err, a_parity_err, a_timeout_err;

  logic [7:0] b_byte_data, b_pix_data, b_img_hres, b_img_vres;
  logic [1:0] b_img_select, b_res_select;
  logic b_byte_valid, b_out_select, b_mon_reset, b_pix_en, b_pix_valid, b_pix_done;
  logic b_frame_err, b_parity_err, b_timeout_err;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .PARITY(0), .TIMEOUT_CLKS(TO)) dut (
    .CLK(clk), .RST(rst), .RX(rx0),
    .byte_data(a_byte_data), .byte_valid(a_byte_valid),
    .img_select(a_img_select), .res_select(a_res_select),
    .out_select(a_out_select), .mon_reset(a_mon_reset),
    .pix_en(a_pix_en), .pix_data(a_pix_data), .pix_valid(a_pix_valid),
    .pix_done(a_pix_done), .img_hres(a_img_hres), .img_vres(a_img_vres),
    .frame_err(a_frame_err), .parity_err(a_parity_err), .timeout_err(a_timeout_err)
  );

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .PARITY(2), .TIMEOUT_CLKS(TO)) dut_par (
    .CLK(clk), .RST(rst), .RX(rx2),
    .byte_data(b_byte_data), .byte_valid(b_byte_valid),
    .img_select(b_img_select), .res_select(b_res_select),
    .out_select(b_out_select), .mon_reset(b_mon_reset),
    .pix_en(b_pix_en), .pix_data(b_pix_data), .pix_valid(b_pix_valid),
    .pix_done(b_pix_done), .img_hres(b_img_hres), .img_vres(b_img_vres),
    .frame_err(b_frame_err), .parity_err(b_parity_err), .timeout_err(b_timeout_err)
  );

  logic [63:0] a_all, b_all;
  assign a_all = {19'd0, a_byte_data, a_byte_valid, a_img_select, a_res_select, a_out_select,
                  a_mon_reset, a_pix_en, a_pix_data, a_pix_valid, a_pix_done, a_img_hres,
                  a_img_vres, a_frame_err, a_parity_err, a_timeout_err};
  assign b_all = {19'd0, b_byte_data, b_byte_valid, b_img_select, b_res_select, b_out_select,
                  b_mon_reset, b_pix_en, b_pix_data, b_pix_valid, b_pix_done, b_img_hres,
                  b_img_vres, b_frame_err, b_parity_err, b_timeout_err};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed pulse counters, sampled on the falling edge.
  int cyc = 0;
  int n_bv = 0, n_pv = 0, n_pd = 0, n_pdpv = 0, n_fe = 0, n_pe = 0, n_to = 0;
  int m_bv = 0, m_pe = 0, m_fe = 0;
  int last_bv_cyc = 0, to_cyc = 0;
  logic [7:0] last_pix = 8'd0;

  always @(negedge clk) begin
    cyc++;
    if (a_byte_valid) begin n_bv++; last_bv_cyc = cyc; end
    if (a_pix_valid) begin n_pv++; last_pix = a_pix_data; end
    if (a_pix_done) begin n_pd++; if (a_pix_valid) n_pdpv++; end
    if (a_frame_err) n_fe++;
    if (a_parity_err) n_pe++;
    if (a_timeout_err) begin n_to++; to_cyc = cyc; end
    if (b_byte_valid) m_bv++;
    if (b_parity_err) m_pe++;
    if (b_frame_err) m_fe++;
  end

  // Reference model: byte-level view of what the decoder should do.
  int mode;  // 0 command, 1 width, 2 height, 3 pixels
  int rem;
  logic [1:0] e_img, e_res;
  logic e_out, e_mon, e_pen;
  logic [7:0] e_hres, e_vres, e_last_pix;
  int e_bv = 0, e_pv = 0, e_pd = 0, e_pdpv = 0, e_fe = 0, e_to = 0;
  int e2_bv = 0, e2_pe = 0, e2_fe = 0;

  task automatic model_reset();
    mode = 0; rem = 0;
    e_img = 2'd0; e_res = 2'd0; e_out = 1'b0; e_mon = 1'b0; e_pen = 1'b0;
    e_hres = 8'd0; e_vres = 8'd0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    e_bv++;
    case (mode)
      0: begin
        if (b[7:6] == 2'b00) begin
          e_img = b[5:4]; e_res = b[3:2]; e_out = b[1]; e_mon = b[0];
        end else if (b[7:6] == 2'b01) begin
          mode = 1; e_pen = 1'b1;
        end
      end
      1: begin e_hres = b; mode = 2; end
      2: begin
        e_vres = b;
        rem = int'(e_hres) * int'(b);
        if (rem == 0) begin e_pd++; e_pen = 1'b0; mode = 0; end
        else mode = 3;
      end
      default: begin
        e_pv++; e_last_pix = b; rem--;
        if (rem == 0) begin e_pd++; e_pdpv++; e_pen = 1'b0; mode = 0; end
      end
    endcase
  endtask

  task automatic verify(input string tag);
    check({tag, "/bv"}, n_bv, e_bv);
    check({tag, "/pv"}, n_pv, e_pv);
    check({tag, "/pd"}, n_pd, e_pd);
    check({tag, "/pd_with_pv"}, n_pdpv, e_pdpv);
    if (e_pv > 0) check({tag, "/pix"}, last_pix, e_last_pix);
    check({tag, "/sel"}, {a_img_select, a_res_select, a_out_select, a_mon_reset},
          {e_img, e_res, e_out, e_mon});
    check({tag, "/pix_en"}, a_pix_en, e_pen);
    check({tag, "/hv"}, {a_img_hres, a_img_vres}, {e_hres, e_vres});
    check({tag, "/fe"}, n_fe, e_fe);
    check({tag, "/pe"}, n_pe, 0);
    check({tag, "/to"}, n_to, e_to);
  endtask

  task automatic put_bit(input int line, input logic v);
    if (line == 0) rx0 = v; else rx2 = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int line, input logic [7:0] b, input logic stop_bit,
                      input logic par_on, input logic par_flip);
    logic p;
    p = (^b) ^ par_flip;
    put_bit(line, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(line, b[i]);
    if (par_on) put_bit(line, p);
    put_bit(line, stop_bit);
    if (line == 0) rx0 = 1'b1; else rx2 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b, input string tag);
    send(0, b, 1'b1, 1'b0, 1'b0);
    model_byte(b);
    verify(tag);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, h, v;
    int kind, ok;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_a", a_all, 64'd0);
    check("reset_b", b_all, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Command byte 0x2B.
    send_good(8'h2B, "cmd2B");
    check("cmd2B/img", a_img_select, 2'd2);
    check("cmd2B/res", a_res_select, 2'd2);
    check("cmd2B/out_mon", {a_out_select, a_mon_reset}, 2'b11);

    // 2x3 download.
    send_good(8'h40, "dl_op");
    send_good(8'h02, "dl_h");
    send_good(8'h03, "dl_v");
    for (int i = 0; i < 6; i++) send_good(8'h10 + 8'(i), "dl_pix");
    check("dl/last_pix", last_pix, 8'h15);
    check("dl/hv", {a_img_hres, a_img_vres}, 16'h0203);
    check("dl/pix_en_low", a_pix_en, 1'b0);
    send_good(8'h00, "after_dl_cmd");

    // Zero-size image.
    send_good(8'h40, "z_op");
    send_good(8'h00, "z_h");
    send_good(8'h05, "z_v");
    send_good(8'h1C, "z_cmd");

    // Stop bit low: frame error, nothing decoded.
    send(0, 8'h3F, 1'b0, 1'b0, 1'b0);
    e_fe++;
    verify("frame_err");

    // Short low glitch on the line.
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    verify("glitch");

    // Reserved opcodes.
    send_good(8'h80 | 8'($urandom_range(0, 127)), "op_rsvd");

    // Randomized mix of commands, reserved opcodes and downloads,
    // with occasional framing errors that must be ignored.
    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        send_good(8'($urandom_range(0, 63)), "r_cmd");
      end else if (kind == 1) begin
        send_good(8'($urandom_range(128, 255)), "r_rsvd");
      end else begin
        h = 8'($urandom_range(0, 3));
        v = 8'($urandom_range(0, 3));
        send_good(8'h40 | 8'($urandom_range(0, 63)), "r_op");
        send_good(h, "r_h");
        if ($urandom_range(0, 3) == 0) begin
          send(0, 8'($urandom), 1'b0, 1'b0, 1'b0);
          e_fe++;
          verify("r_fe");
        end
        send_good(v, "r_v");
        for (int p = 0; p < int'(h) * int'(v); p++) begin
          send_good(8'($urandom), "r_pix");
          if ($urandom_range(0, 7) == 0) begin
            send(0, 8'($urandom), 1'b0, 1'b0, 1'b0);
            e_fe++;
            verify("r_pix_fe");
          end
        end
      end
    end

    // Even-parity instance.
    send(1, 8'h01, 1'b1, 1'b1, 1'b1);
    e2_pe++;
    check("par/pe", m_pe, e2_pe);
    check("par/bv", m_bv, e2_bv);
    send(1, 8'h2B, 1'b1, 1'b1, 1'b0);
    e2_bv++;
    check("par/good_bv", m_bv, e2_bv);
    check("par/good_data", b_byte_data, 8'h2B);
    check("par/good_sel", {b_img_select, b_res_select, b_out_select, b_mon_reset}, 6'b101011);
    send(1, 8'h55, 1'b0, 1'b1, 1'b1);
    e2_fe++;
    check("par/fe_prio_fe", m_fe, e2_fe);
    check("par/fe_prio_pe", m_pe, e2_pe);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 1);
      send(1, b, 1'b1, 1'b1, kind[0]);
      if (kind == 1) e2_pe++;
      else begin
        e2_bv++;
        check("par/r_data", b_byte_data, b);
      end
      check("par/r_bv", m_bv, e2_bv);
      check("par/r_pe", m_pe, e2_pe);
    end
    check("par/fe_total", m_fe, e2_fe);

    // Inter-byte timeout during a 4x4 download.
    send_good(8'h40, "to_op");
    send_good(8'h04, "to_h");
    send_good(8'h04, "to_v");
    for (int i = 0; i < 3; i++) send_good(8'($urandom), "to_pix");
    for (int w = 0; w < 3000 && (cyc - last_bv_cyc) < 1990; w++) @(negedge clk);
    check("to/not_early", n_to, e_to);
    check("to/pix_en_hold", a_pix_en, 1'b1);
    for (int w = 0; w < 200 && n_to == e_to; w++) @(negedge clk);
    check("to/fired", n_to, e_to + 1);
    ok = ((to_cyc - last_bv_cyc) >= 1998 && (to_cyc - last_bv_cyc) <= 2004) ? 1 : 0;
    check("to/window", ok, 1);
    e_to++;
    e_pen = 1'b0;
    mode = 0;
    repeat (5) @(negedge clk);
    verify("to_after");
    check("to/hv_kept", {a_img_hres, a_img_vres}, 16'h0404);
    send_good(8'h2A, "to_cmd");

    // Reset in the middle of a frame.
    send_good(8'h3F, "pre_rst");
    put_bit(0, 1'b0);
    put_bit(0, 1'b1);
    put_bit(0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_a", a_all, 64'd0);
    check("rst_mid_b", b_all, 64'd0);
    rx0 = 1'b1;
    rst = 1'b0;
    model_reset();
    repeat (40) @(negedge clk);
    verify("post_rst");
    send_good(8'h26, "post_rst_cmd");
    check("post_rst/data", a_byte_data, 8'h26);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
